// File: rtl/qsys_avmm_pkg.sv
// Shared types and constants for the Avalon-MM command master.
package qsys_avmm_pkg;

  // Stall counter width; wide enough for any TIMEOUT in 1..65535.
  localparam int unsigned CNT_W = 16;

  // Default stall limit before an access is abandoned.
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage : qsys_avmm_pkg

// File: rtl/qsys_avmm_timeout.sv
// Waitrequest stall counter. 'expired' is high when the next stall would be
// the TIMEOUT-th one, so the master can abandon on exactly that stall cycle.
module qsys_avmm_timeout
  import qsys_avmm_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count stall cycles; saturate at the limit so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count   <= '0;
      expired <= (LAST == '0);
    end else if (enable && !expired) begin
      count   <= count + CNT_W'(1);
      expired <= ((count + CNT_W'(1)) == LAST);
    end
  end

endmodule : qsys_avmm_timeout

// File: rtl/qsys_avmm_master.sv
// Single-outstanding Avalon-MM master: accepts one command, runs it on the
// bus with waitrequest timeout, and holds the response until consumed.
module qsys_avmm_master
  import qsys_avmm_pkg::*;
#(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  // Avalon-MM master
  output logic [ADDR_W-1:0] av_address,
  output logic              av_chipselect,
  output logic              av_write_n,
  output logic              av_read_n,
  output logic [DATA_W-1:0] av_writedata,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_waitrequest
);

  state_e state;
  logic   write_q;
  logic   tmo_clear;
  logic   tmo_enable;
  logic   tmo_expired;

  // Counter restarts on each accepted command and counts stalled ACCESS cycles.
  assign tmo_clear  = (state == ST_IDLE) && cmd_valid;
  assign tmo_enable = (state == ST_ACCESS) && av_waitrequest;

  qsys_avmm_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // Command/access/response FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_rdata     <= '0;
      write_q       <= 1'b0;
      av_address    <= '0;
      av_writedata  <= '0;
      av_chipselect <= 1'b0;
      av_write_n    <= 1'b1;
      av_read_n     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state         <= ST_ACCESS;
            cmd_ready     <= 1'b0;
            write_q       <= cmd_write;
            av_address    <= cmd_address;
            av_writedata  <= cmd_wdata;
            av_chipselect <= 1'b1;
            av_write_n    <= ~cmd_write;
            av_read_n     <= cmd_write;
          end
        end
        ST_ACCESS: begin
          if (!av_waitrequest || tmo_expired) begin
            state         <= ST_RESP;
            rsp_valid     <= 1'b1;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_read_n     <= 1'b1;
            if (!av_waitrequest) begin
              rsp_error <= 1'b0;
              rsp_rdata <= write_q ? '0 : av_readdata;
            end else begin
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state         <= ST_IDLE;
          cmd_ready     <= 1'b1;
          rsp_valid     <= 1'b0;
          av_chipselect <= 1'b0;
          av_write_n    <= 1'b1;
          av_read_n     <= 1'b1;
        end
      endcase
    end
  end

endmodule : qsys_avmm_master

// File: tb/tb_qsys_avmm_master.sv
// Bench for qsys_avmm_master: small PIO/RAM slave with programmable stalls,
// directed scenarios plus random transactions against a reference model.
module tb_qsys_avmm_master;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_address;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [1:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic        av_read_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_waitrequest;

  qsys_avmm_master #(
    .ADDR_W  (2),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_address    (cmd_address),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .av_address     (av_address),
    .av_chipselect  (av_chipselect),
    .av_write_n     (av_write_n),
    .av_read_n      (av_read_n),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave environment ----------------
  logic [3:0]  pio;
  logic [31:0] ram [4];
  int          stall_left;
  int          cs_count;
  logic        bus_bad;
  logic [1:0]  exp_addr;
  logic        exp_wr;
  logic [31:0] exp_wdata;

  assign av_waitrequest = av_chipselect && (stall_left != 0);

  always_comb begin
    case (av_address)
      2'd0:    av_readdata = {28'd0, pio};
      2'd1:    av_readdata = 32'd0;
      default: av_readdata = ram[av_address];
    endcase
  end

  // Slave: stall countdown, write capture, bus-content monitor.
  always @(posedge clk) begin
    if (av_chipselect) begin
      cs_count = cs_count + 1;
      if (av_address != exp_addr || av_write_n != !exp_wr || av_read_n != exp_wr ||
          (exp_wr && av_writedata != exp_wdata))
        bus_bad = 1'b1;
      if (av_waitrequest) stall_left = stall_left - 1;
      else if (!av_write_n) begin
        case (av_address)
          2'd0:    pio = av_writedata[3:0];
          2'd1:    ;
          default: ram[av_address] = av_writedata;
        endcase
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] model_mem [4];

  task automatic do_txn(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                        input int stalls, input int rdly, input logic hold_valid);
    logic        e_err;
    logic [31:0] e_rd;
    int          e_cs;
    int          n;
    if (stalls >= int'(TO)) begin
      e_err = 1'b1; e_rd = 32'd0; e_cs = int'(TO);
    end else begin
      e_err = 1'b0; e_cs = stalls + 1;
      if (wr) begin
        e_rd = 32'd0;
        if (addr == 2'd0) model_mem[0] = {28'd0, wdata[3:0]};
        else if (addr != 2'd1) model_mem[addr] = wdata;
      end else begin
        e_rd = model_mem[addr];
      end
    end

    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    exp_addr = addr; exp_wr = wr; exp_wdata = wdata;
    bus_bad = 1'b0; cs_count = 0; stall_left = stalls;
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cmd_valid   = hold_valid;
    cmd_write   = 1'($urandom);
    cmd_address = 2'($urandom);
    cmd_wdata   = $urandom;
    n = 0;
    while (!rsp_valid && n < int'(TO) + 8) begin @(negedge clk); n++; end
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("latency", 64'(n), 64'(e_cs));
    check("cs_cycles", 64'(cs_count), 64'(e_cs));
    check("cs_low", 64'(av_chipselect), 64'd0);
    check("bus", 64'(bus_bad), 64'd0);
    for (int i = 0; i < rdly; i++) begin
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_rdata", 64'(rsp_rdata), 64'(e_rd));
      check("hold_error", 64'(rsp_error), 64'(e_err));
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
    end
    check("rdata", 64'(rsp_rdata), 64'(e_rd));
    check("error", 64'(rsp_error), 64'(e_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    check("idle_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    pio = 4'd0; stall_left = 0; cs_count = 0; bus_bad = 1'b0;
    exp_addr = 2'd0; exp_wr = 1'b0; exp_wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin ram[i] = 32'd0; model_mem[i] = 32'd0; end
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 2'd0;
    cmd_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_error", 64'(rsp_error), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_cs", 64'(av_chipselect), 64'd0);
    check("rst_write_n", 64'(av_write_n), 64'd1);
    check("rst_read_n", 64'(av_read_n), 64'd1);
    check("rst_addr", 64'(av_address), 64'd0);
    check("rst_wdata", 64'(av_writedata), 64'd0);
    reset = 1'b0;

    // PIO write, readback, unmapped read
    do_txn(1'b1, 2'd0, 32'h5, 0, 0, 1'b0);
    check("pio_out", 64'(pio), 64'h5);
    do_txn(1'b0, 2'd0, 32'h0, 0, 0, 1'b0);
    do_txn(1'b0, 2'd1, 32'h0, 0, 0, 1'b0);
    // stalled read of a known pattern
    do_txn(1'b1, 2'd2, 32'hA5A5A5A5, 0, 0, 1'b0);
    do_txn(1'b0, 2'd2, 32'h0, 3, 0, 1'b0);
    // stuck waitrequest -> timeout
    do_txn(1'b0, 2'd2, 32'h0, 1000, 0, 1'b0);
    // exactly TIMEOUT stalls still times out; one fewer completes
    do_txn(1'b1, 2'd3, 32'h1234_5678, int'(TO), 0, 1'b0);
    do_txn(1'b0, 2'd3, 32'h0, int'(TO) - 1, 0, 1'b0);
    // response back-pressure with a pending command, then next command
    do_txn(1'b0, 2'd2, 32'h0, 0, 5, 1'b1);
    do_txn(1'b1, 2'd0, 32'hC, 1, 0, 1'b0);
    check("pio_out2", 64'(pio), 64'hC);

    // random traffic
    for (int k = 0; k < 60; k++) begin
      int r;
      int st;
      r = int'($urandom_range(0, 9));
      if (r < 5) st = 0;
      else if (r < 8) st = int'($urandom_range(1, TO - 1));
      else st = int'($urandom_range(TO, TO + 2));
      do_txn(1'($urandom), 2'($urandom), $urandom, st,
             int'($urandom_range(0, 3)), 1'($urandom));
    end

    // reset during a stalled access
    @(negedge clk);
    stall_left = 1000; cs_count = 0;
    exp_addr = 2'd2; exp_wr = 1'b0; exp_wdata = 32'd0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_cs", 64'(av_chipselect), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_cs", 64'(av_chipselect), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    check("post_rst_cs", 64'(av_chipselect), 64'd0);
    do_txn(1'b0, 2'd0, 32'h0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_qsys_avmm_master
